// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES-over-SPI transaction sequencer.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendText,
    StSendSize,
    StSendKey,
    StWaitRes,
    StRecv,
    StFinish
  } state_e;

  localparam logic [1:0] KEY_SEL_128 = 2'd0;
  localparam logic [1:0] KEY_SEL_192 = 2'd1;
  localparam logic [1:0] KEY_SEL_256 = 2'd2;
  localparam logic [1:0] KEY_SEL_BAD = 2'd3;

  localparam logic [7:0] SIZE_128 = 8'd16;
  localparam logic [7:0] SIZE_192 = 8'd24;
  localparam logic [7:0] SIZE_256 = 8'd32;

  localparam int unsigned TEXT_BYTES = 16;
  localparam int unsigned SIZE_BYTES = 1;
  localparam int unsigned KEY_BYTES  = 32;
  localparam int unsigned RES_BYTES  = 16;

  function automatic logic [7:0] size_byte(input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      KEY_SEL_192: b = SIZE_192;
      KEY_SEL_256: b = SIZE_256;
      default:     b = SIZE_128;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_frame_serializer.sv
// Selects the outgoing SPI byte from the current frame position and latched data.
module aes_frame_serializer
  import aes_spi_pkg::*;
#(
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input  state_e       state,
  input  logic [4:0]   idx,
  input  logic [127:0] text,
  input  logic [255:0] key,
  input  logic [7:0]   size,
  output logic [7:0]   tx
);

  // MSB-first: byte n lives at bit offset 8*(last-n), and last-n == ~n for power-of-two frames.
  logic [6:0] text_sel;
  logic [7:0] key_sel;

  assign text_sel = {~idx[3:0], 3'b000};
  assign key_sel  = {~idx[4:0], 3'b000};

  always_comb begin
    tx = 8'h00;
    case (state)
      StSendText: tx = text[text_sel +: 8];
      StSendSize: tx = size;
      StSendKey:  tx = key[key_sel +: 8];
      StRecv:     tx = DUMMY_BYTE;
      default:    tx = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_spi_sequencer.sv
// Runs one AES encrypt transaction (text, size, key, result read-back) over an SPI byte master.
module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  DUMMY_BYTE     = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [255:0] key,
  input  logic [1:0]   key_sel,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] cipher_text,
  output logic         spi_start,
  output logic [7:0]   spi_tx,
  input  logic         spi_busy,
  input  logic         spi_done,
  input  logic [7:0]   spi_rx,
  input  logic         enc_sending
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           out_q, out_d;
  logic           spi_start_q, spi_start_d;
  logic           err_q, err_d;
  logic [127:0]   text_q;
  logic [255:0]   key_q;
  logic [7:0]     size_q;
  logic [127:0]   cap_q, cap_d;
  logic [127:0]   cipher_q, cipher_d;
  logic           latch;
  logic           expired;
  logic           xfer_done;

  assign expired   = (cnt_q == CntLast);
  assign xfer_done = out_q && spi_done;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    spi_start_d = 1'b0;
    err_d       = err_q;
    cap_d       = cap_q;
    cipher_d    = cipher_q;
    latch       = 1'b0;

    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (start) begin
          if (key_sel == KEY_SEL_BAD) begin
            state_d = StFinish;
            err_d   = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = StSendText;
            idx_d   = '0;
            cnt_d   = '0;
            out_d   = 1'b0;
          end
        end
      end

      StSendText, StSendSize, StSendKey, StRecv: begin
        if (xfer_done) begin
          // A completing byte beats a simultaneous timeout expiry.
          out_d = 1'b0;
          cnt_d = '0;
          idx_d = idx_q + 5'd1;
          if (state_q == StSendText && idx_q == 5'(TEXT_BYTES - 1)) begin
            state_d = StSendSize;
            idx_d   = '0;
          end else if (state_q == StSendSize && idx_q == 5'(SIZE_BYTES - 1)) begin
            state_d = StSendKey;
            idx_d   = '0;
          end else if (state_q == StSendKey && idx_q == 5'(KEY_BYTES - 1)) begin
            state_d = StWaitRes;
            idx_d   = '0;
          end else if (state_q == StRecv) begin
            cap_d = {cap_q[119:0], spi_rx};
            if (idx_q == 5'(RES_BYTES - 1)) begin
              cipher_d = cap_d;
              state_d  = StFinish;
              err_d    = 1'b0;
              idx_d    = '0;
            end
          end
        end else if (out_q) begin
          if (expired) begin
            state_d = StFinish;
            err_d   = 1'b1;
            out_d   = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (!spi_busy) begin
          spi_start_d = 1'b1;
          out_d       = 1'b1;
          cnt_d       = '0;
        end
      end

      StWaitRes: begin
        if (enc_sending) begin
          state_d = StRecv;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = StFinish;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StFinish: begin
        state_d = StIdle;
        err_d   = 1'b0;
        cnt_d   = '0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      spi_start_q <= 1'b0;
      err_q       <= 1'b0;
      text_q      <= '0;
      key_q       <= '0;
      size_q      <= '0;
      cap_q       <= '0;
      cipher_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      spi_start_q <= spi_start_d;
      err_q       <= err_d;
      cap_q       <= cap_d;
      cipher_q    <= cipher_d;
      if (latch) begin
        text_q <= plain_text;
        key_q  <= key;
        size_q <= size_byte(key_sel);
      end
    end
  end

  aes_frame_serializer #(
    .DUMMY_BYTE(DUMMY_BYTE)
  ) u_serializer (
    .state(state_q),
    .idx  (idx_q),
    .text (text_q),
    .key  (key_q),
    .size (size_q),
    .tx   (spi_tx)
  );

  assign busy        = (state_q != StIdle) && (state_q != StFinish);
  assign done        = (state_q == StFinish);
  assign err         = err_q;
  assign cipher_text = cipher_q;
  assign spi_start   = spi_start_q;

endmodule
